// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch, decode and
// per-opcode execute states, plus a retired-instruction counter.
module multicycle_control (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        iord,
   output logic        irwrite,
   output logic        pcwrite,
   output logic        branch,
   output logic        memwrite,
   output logic        regwrite,
   output logic        regdst,
   output logic        memtoreg,
   output logic        alusrca,
   output logic [1:0]  alusrcb,
   output logic [1:0]  pcsrc,
   output logic [1:0]  aluop,
   output logic [3:0]  state,
   output logic        illegal,
   output logic        instr_done,
   output logic [15:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXEC = 4'd6,
      S_RTWB   = 4'd7,
      S_BEQEX  = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   state_e      state_q, state_d;
   logic [15:0] retired_q, retired_d;

   // State register and retired counter; reset overrides every transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTEXEC;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_RTEXEC: state_d = S_RTWB;
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      mem_req    = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      aluop      = 2'b00;
      illegal    = 1'b0;
      instr_done = 1'b0;
      case (state_q)
         S_FETCH: begin
            // IR/PC load only on the completing cycle, so waits never double-fetch.
            mem_req = 1'b1;
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcwrite = mem_ready;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            illegal = !(opcode inside {OP_RTYPE, OP_BEQ, OP_ADDI, OP_LW, OP_SW});
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            mem_req    = 1'b1;
            iord       = 1'b1;
            memwrite   = 1'b1;
            instr_done = mem_ready;
         end
         S_RTEXEC: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         S_RTWB: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BEQEX: begin
            alusrca    = 1'b1;
            aluop      = 2'b01;
            pcsrc      = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      retired_d = instr_done ? retired_q + 16'd1 : retired_q;
   end

   assign state   = state_q;
   assign retired = retired_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 opcode  input  6  instruction bits [31:26]; sampled only in DECODE, from the instruction register.
REQ-004 mem_ready  input  1  memory completion; qualifies FETCH, MEMRD and MEMWR.
REQ-005 mem_req  output  1  memory access request.
REQ-006 iord, irwrite, pcwrite, branch, memwrite, regwrite, regdst, memtoreg, alusrca  output  1 each  datapath controls.
REQ-007 alusrcb, pcsrc, aluop  output  2 each  datapath selects.
REQ-008 state  output  4  current state encoding, for debug.
REQ-009 illegal  output  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-010 instr_done  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-011 retired  output  16  count of completed instructions.

Function
REQ-012 Controller SHALL be a Moore FSM; all outputs SHALL decode from the registered state, except the mem_ready-qualified strobes in REQ-016.
REQ-013 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10; encodings 11-15 SHALL go to FETCH on the next edge.
REQ-014 Transitions SHALL be:
- FETCH->DECODE when mem_ready=1, else stay in FETCH.
- From DECODE, by opcode: 35 or 43 -> MEMADR; 0 -> RTEXEC; 4 -> BEQEX; 8 -> ADDIEX; any other opcode -> FETCH with illegal=1.
- MEMADR -> MEMRD if opcode=35, else MEMWR.
- MEMRD -> MEMWB when mem_ready=1, else stay; MEMWR -> FETCH when mem_ready=1, else stay.
- MEMWB, RTWB, BEQEX and ADDIWB -> FETCH.
- RTEXEC -> RTWB; ADDIEX -> ADDIWB.
REQ-015 Per-state outputs; all unlisted outputs SHALL be 0:
- FETCH: mem_req=1, alusrcb=01.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: mem_req=1, iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: mem_req=1, iord=1, memwrite=1.
- RTEXEC: alusrca=1, aluop=10.
- RTWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
REQ-016 In FETCH, irwrite and pcwrite SHALL equal mem_ready, so they pulse exactly once per fetch regardless of wait cycles.
REQ-017 memwrite SHALL be held for the whole MEMWR stay; the write commits on the cycle where mem_ready=1.
REQ-018 instr_done SHALL be 1 in MEMWB, RTWB, BEQEX and ADDIWB, and in MEMWR when mem_ready=1; otherwise 0.
REQ-019 retired SHALL increment by 1 on every edge where instr_done=1, wrapping from 0xFFFF to 0x0000; illegal opcodes SHALL NOT increment it.
REQ-020 illegal SHALL be 1 only in DECODE with an unsupported opcode.
REQ-021 Minimum latency without wait states SHALL be: lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; illegal 2 (FETCH+DECODE).
REQ-022 mem_ready SHALL be ignored in all states other than FETCH, MEMRD and MEMWR.

Reset
REQ-023 reset=1 at an edge SHALL force state=FETCH and retired=0, overriding any transition, including during memory wait states.
REQ-024 After reset, outputs SHALL be the FETCH values with irwrite=pcwrite=mem_ready, and illegal=0, instr_done=0.

Verification
REQ-025 lw (opcode 35), mem_ready tied 1 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; retired 0->1.
REQ-026 sw (opcode 43), mem_ready low for 3 cycles in MEMWR -> state 5 held 4 cycles with memwrite=1; instr_done only in the final cycle; next state 0.
REQ-027 FETCH with mem_ready low for 2 cycles, then high -> mem_req=1 for 3 cycles; irwrite and pcwrite single-cycle pulse; then DECODE.
REQ-028 Sequence beq(4), addi(8), R-type(0), opcode 2 -> beq: branch=1, pcsrc=01 in state 8; addi and R-type take 4 cycles each; opcode 2: illegal pulse, back to FETCH; retired=3.
REQ-029 retired preloaded to 0xFFFF via 65535 instructions, then one more R-type -> retired=0x0000.
REQ-030 reset asserted in MEMRD while mem_ready=0 -> next state FETCH, retired=0, regwrite never asserted.
